// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX field sequencer.
package fix_pkg;
  localparam logic [7:0] SOH_C       = 8'h01;
  localparam logic [7:0] SEP_C       = 8'h3D;
  localparam int         CHK_TAG     = 10;
  localparam int         BODYLEN_TAG = 9;

  typedef enum logic [1:0] {TAG, VALUE, CHKVAL, SKIP} fix_state_e;

  typedef enum logic [1:0] {
    ERR_TAG_CHAR = 2'd0,
    ERR_TAG_OVF  = 2'd1,
    ERR_NO_SEP   = 2'd2,
    ERR_LEN_OVF  = 2'd3
  } fix_err_e;
endpackage

// File: rtl/fix_byte_lane_buf.sv
// One-word ingress buffer that presents its four bytes one per cycle, lane 0 first.
module fix_byte_lane_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  byte_o,
  output logic        byte_vld_o,
  output logic        nxt_vld_o
);
  logic [31:0] wbuf_q, wbuf_d;
  logic        vld_q, vld_d;
  logic [1:0]  lane_q, lane_d;

  // Accepting on the last lane keeps the byte stream gapless under back-to-back words.
  assign ready_o = !vld_q || (lane_q == 2'd3);

  always_comb begin
    wbuf_d = wbuf_q;
    vld_d  = vld_q;
    lane_d = lane_q;
    if (ready_o) begin
      vld_d  = valid_i;
      lane_d = 2'd0;
      if (valid_i) wbuf_d = data_i;
    end else begin
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbuf_q <= '0;
      vld_q  <= 1'b0;
      lane_q <= 2'd0;
    end else begin
      wbuf_q <= wbuf_d;
      vld_q  <= vld_d;
      lane_q <= lane_d;
    end
  end

  assign byte_o     = wbuf_q[{lane_q, 3'b000} +: 8];
  assign byte_vld_o = vld_q;
  assign nxt_vld_o  = vld_d;
endmodule

// File: rtl/fix_field_seq.sv
// FIX tag/value framing tracker: emits one descriptor per field, checks the tag-10
// checksum against the running byte sum and flags framing errors.
module fix_field_seq
  import fix_pkg::*;
#(
  parameter int TAG_W          = 16,
  parameter int LEN_W          = 12,
  parameter int MAX_TAG_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             tag_status_o,
  output logic             body_status_o,
  output logic             fld_valid_o,
  output logic [TAG_W-1:0] fld_tag_o,
  output logic [LEN_W-1:0] fld_len_o,
  output logic             msg_done_o,
  output logic             chk_ok_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);
  localparam int DCW = $clog2(MAX_TAG_DIGITS + 1);
  localparam int TW4 = TAG_W + 4;

  logic [7:0] cur_b;
  logic       bvld, nvld;

  fix_byte_lane_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .byte_o    (cur_b),
    .byte_vld_o(bvld),
    .nxt_vld_o (nvld)
  );

  fix_state_e       state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d, ftag_q, ftag_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [LEN_W-1:0] len_q, len_d, flen_q, flen_d;
  logic [9:0]       cval_q, cval_d;
  logic [7:0]       sum_q, sum_d, snap_q, snap_d;
  logic             body_q, body_d, cok_q, cok_d, fvld_q, fvld_d;
  logic             done_q, done_d, err_q, err_d, tst_q, tst_d;
  fix_err_e         code_q, code_d;

  logic           is_dig, is_sep, is_soh, dig_full, tag_ovf, len_full, tag_is_chk;
  logic [3:0]     dig;
  logic [TW4-1:0] tag_nxt;

  assign is_dig     = (cur_b >= 8'h30) && (cur_b <= 8'h39);
  assign is_sep     = cur_b == SEP_C;
  assign is_soh     = cur_b == SOH_C;
  assign dig        = 4'(cur_b - 8'h30);
  assign tag_nxt    = TW4'(tag_q) * TW4'(10) + TW4'(dig);
  assign tag_ovf    = |tag_nxt[TW4-1:TAG_W];
  assign dig_full   = dcnt_q == DCW'(MAX_TAG_DIGITS);
  assign len_full   = &len_q;
  assign tag_is_chk = tag_q == TAG_W'(CHK_TAG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TAG;
      tag_q   <= '0;  dcnt_q <= '0;  len_q  <= '0;  cval_q <= '0;
      sum_q   <= '0;  snap_q <= '0;  ftag_q <= '0;  flen_q <= '0;
      body_q  <= 1'b0; cok_q <= 1'b0; fvld_q <= 1'b0; done_q <= 1'b0;
      err_q   <= 1'b0; tst_q <= 1'b0; code_q <= ERR_TAG_CHAR;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;   dcnt_q <= dcnt_d;  len_q  <= len_d;   cval_q <= cval_d;
      sum_q   <= sum_d;   snap_q <= snap_d;  ftag_q <= ftag_d;  flen_q <= flen_d;
      body_q  <= body_d;  cok_q  <= cok_d;   fvld_q <= fvld_d;  done_q <= done_d;
      err_q   <= err_d;   tst_q  <= tst_d;   code_q <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bvld) begin
      case (state_q)
        TAG: begin
          if (is_dig)                    state_d = (dig_full || tag_ovf) ? SKIP : TAG;
          else if (is_sep && dcnt_q != 0) state_d = tag_is_chk ? CHKVAL : VALUE;
          else if (is_sep || is_soh)     state_d = TAG;
          else                           state_d = SKIP;
        end
        VALUE, CHKVAL: begin
          if (is_soh)        state_d = TAG;
          else if (len_full) state_d = SKIP;
        end
        SKIP:    if (is_soh) state_d = TAG;
        default: state_d = TAG;
      endcase
    end
  end

  always_comb begin
    logic clr;
    clr    = 1'b0;
    tag_d  = tag_q;   dcnt_d = dcnt_q;  len_d  = len_q;   cval_d = cval_q;
    sum_d  = sum_q;   snap_d = snap_q;  ftag_d = ftag_q;  flen_d = flen_q;
    body_d = body_q;  cok_d  = cok_q;   code_d = code_q;
    fvld_d = 1'b0;    done_d = 1'b0;    err_d  = 1'b0;
    tst_d  = (state_d == TAG) && nvld;
    if (bvld) begin
      sum_d = sum_q + cur_b;
      case (state_q)
        TAG: begin
          if (dcnt_q == 0) snap_d = sum_q;
          if (is_dig) begin
            if (dig_full || tag_ovf) begin
              err_d = 1'b1; code_d = ERR_TAG_OVF;
            end else begin
              tag_d  = tag_nxt[TAG_W-1:0];
              dcnt_d = dcnt_q + DCW'(1);
            end
          end else if (is_sep && dcnt_q != 0) begin
            len_d  = '0;
            cval_d = '0;
            // The tag number is only known at '=', so the body flag drops here.
            if (tag_is_chk) body_d = 1'b0;
          end else if (is_sep || is_soh) begin
            err_d = 1'b1; code_d = ERR_NO_SEP; clr = 1'b1;
          end else begin
            err_d = 1'b1; code_d = ERR_TAG_CHAR;
          end
        end
        VALUE, CHKVAL: begin
          if (is_soh) begin
            fvld_d = 1'b1;
            ftag_d = tag_q;
            flen_d = len_q;
            clr    = 1'b1;
            if (state_q == CHKVAL) begin
              done_d = 1'b1;
              cok_d  = cval_q == {2'b00, snap_q};
              sum_d  = '0;
              body_d = 1'b0;
            end else if (tag_q == TAG_W'(BODYLEN_TAG)) begin
              body_d = 1'b1;
            end
          end else if (len_full) begin
            err_d = 1'b1; code_d = ERR_LEN_OVF;
          end else begin
            len_d = len_q + LEN_W'(1);
            if (state_q == CHKVAL) cval_d = cval_q * 10'd10 + {6'd0, dig};
          end
        end
        SKIP:    if (is_soh) clr = 1'b1;
        default: ;
      endcase
      if (clr) begin
        tag_d = '0; dcnt_d = '0; len_d = '0; cval_d = '0;
      end
    end
  end

  assign tag_status_o  = tst_q;
  assign body_status_o = body_q;
  assign fld_valid_o   = fvld_q;
  assign fld_tag_o     = ftag_q;
  assign fld_len_o     = flen_q;
  assign msg_done_o    = done_q;
  assign chk_ok_o      = cok_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;
endmodule

// File: tb/tb_fix_field_seq.sv
// Scoreboard bench: stimulus pushes hand-computed descriptors/errors, a negedge monitor pops and compares.
module tb_fix_field_seq;
  localparam int TAG_W = 16;
  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      data_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o, tag_status_o, body_status_o, fld_valid_o, msg_done_o, chk_ok_o, err_o;
  logic [TAG_W-1:0] fld_tag_o;
  logic [LEN_W-1:0] fld_len_o;
  logic [1:0]       err_code_o;

  always #5 clk = ~clk;

  fix_field_seq #(.TAG_W(TAG_W), .LEN_W(LEN_W), .MAX_TAG_DIGITS(5)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .tag_status_o(tag_status_o), .body_status_o(body_status_o),
    .fld_valid_o(fld_valid_o), .fld_tag_o(fld_tag_o), .fld_len_o(fld_len_o),
    .msg_done_o(msg_done_o), .chk_ok_o(chk_ok_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  typedef struct {
    bit is_err;
    int tag;
    int len;
    bit done;
    bit chk;
    int code;
    bit body;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] bq[$];
  int         checks = 0;
  int         fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void exp_fld(int tag, int len, bit done, bit ok, bit body);
    exp_t e;
    e = '{is_err: 1'b0, tag: tag, len: len, done: done, chk: ok, code: 0, body: body};
    expq.push_back(e);
  endfunction

  function automatic void exp_err(int code, bit ok);
    exp_t e;
    e = '{is_err: 1'b1, tag: 0, len: 0, done: 1'b0, chk: ok, code: code, body: 1'b0};
    expq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (fld_valid_o === 1'b1 || err_o === 1'b1 || msg_done_o === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: fld=%0b err=%0b done=%0b tag=%0d code=%0d, none required",
                 fld_valid_o, err_o, msg_done_o, fld_tag_o, err_code_o);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("event_is_err", 32'(err_o), 32'(e.is_err));
        if (e.is_err) begin
          chk("err_code", 32'(err_code_o), 32'(e.code));
        end else begin
          chk("fld_tag", 32'(fld_tag_o), 32'(e.tag));
          chk("fld_len", 32'(fld_len_o), 32'(e.len));
          chk("msg_done", 32'(msg_done_o), 32'(e.done));
          chk("body_status", 32'(body_status_o), 32'(e.body));
        end
        chk("chk_ok", 32'(chk_ok_o), 32'(e.chk));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      bq.push_back((c == 8'h7C) ? 8'h01 : c);  // '|' stands for SOH
    end
  endtask

  task automatic add_rep(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) bq.push_back(c);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    valid_i = 1'b1;
    data_i  = w;
    while (!ready_o && n < 64) begin
      tick();
      n++;
    end
    if (!ready_o) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: ready_o stayed 0 for %0d cycles, required 1", n);
    end
    tick();
    valid_i = 1'b0;
  endtask

  task automatic send_all(input int gap);
    while (bq.size() >= 4) begin
      logic [31:0] w;
      w = {bq[3], bq[2], bq[1], bq[0]};
      repeat (4) void'(bq.pop_front());
      send_word(w);
      repeat (gap) tick();
    end
  endtask

  task automatic drain(input string nm);
    repeat (20) tick();
    chk(nm, 32'(expq.size()), 32'd0);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_fld_valid"}, 32'(fld_valid_o), 0);
    chk({nm, "_msg_done"}, 32'(msg_done_o), 0);
    chk({nm, "_err"}, 32'(err_o), 0);
    chk({nm, "_chk_ok"}, 32'(chk_ok_o), 0);
    chk({nm, "_body"}, 32'(body_status_o), 0);
    chk({nm, "_tag_status"}, 32'(tag_status_o), 0);
    chk({nm, "_fld_tag"}, 32'(fld_tag_o), 0);
    chk({nm, "_fld_len"}, 32'(fld_len_o), 0);
    chk({nm, "_err_code"}, 32'(err_code_o), 0);
  endtask

  task automatic send_msg_a(input int gap);
    add_str("1=AB|10=242|");
    exp_fld(1, 2, 0, 0, 0);
    exp_fld(10, 3, 1, 1, 0);
    send_all(gap);
  endtask

  initial begin
    repeat (3) tick();
    reset_checks("reset");
    rst = 1'b1;
    tick();

    // Sum of "1=AB|" is 242: checksum match, then mismatch.
    add_str("1=AB|10=242|");
    exp_fld(1, 2, 0, 0, 0);
    exp_fld(10, 3, 1, 1, 0);
    send_all(0);
    add_str("1=AB|10=241|");
    exp_fld(1, 2, 0, 1, 0);
    exp_fld(10, 3, 1, 0, 0);
    send_all(0);

    // Body flag set after tag 9, still set at tag 35, cleared by tag 10; sum 624 mod 256 = 112.
    add_str("9=1234|35=DE|10=112|");
    exp_fld(9, 4, 0, 0, 1);
    exp_fld(35, 2, 0, 0, 1);
    exp_fld(10, 3, 1, 1, 0);
    send_all(0);

    add_str("3A=x|5=yzab|");
    exp_err(0, 1);
    exp_fld(5, 4, 0, 1, 0);
    send_all(0);

    add_str("123456=7|=5|");
    exp_err(1, 1);
    exp_err(2, 1);
    exp_err(2, 1);
    send_all(0);

    add_str("70000=123|8=abc|");
    exp_err(1, 1);
    exp_fld(8, 3, 0, 1, 0);
    send_all(0);

    add_str("222=");
    add_rep(8'h78, 4095);
    add_str("|");
    exp_fld(222, 4095, 0, 1, 0);
    send_all(0);

    add_str("22=");
    add_rep(8'h78, 4096);
    add_str("|");
    exp_err(3, 1);
    send_all(0);
    drain("drain_main");

    #2 rst = 1'b0;
    #1 reset_checks("reset2");
    tick();
    rst = 1'b1;
    tick();

    send_msg_a(1);
    drain("drain_gap1");
    add_str("1=AB|10=242|");
    exp_fld(1, 2, 0, 1, 0);
    exp_fld(10, 3, 1, 1, 0);
    send_all(5);
    drain("drain_gap5");

    // Partial field "1=AB" cut by reset while in the value.
    send_word(32'h4241_3D31);
    tick();
    tick();
    #2 rst = 1'b0;
    #1 reset_checks("reset_mid");
    tick();
    rst = 1'b1;
    tick();

    send_msg_a(0);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
